// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: opcodes, FSM state encoding and instruction field positions shared by the sequencer files
package cpu_seq_pkg;
    localparam int W_WORD = 19;
    localparam int OPC_HI = 16;
    localparam int OPC_LO = 14;
    localparam int IMM_HI = 13;
    localparam int IMM_LO = 2;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 2;
    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b100;
    localparam logic [2:0] OP_LDB  = 3'b101;
    localparam logic [2:0] OP_LDC  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_ALU, S_HALT} state_t;
endpackage

// File: rtl/cpu_instr_sequencer_if.sv
// cpu_instr_sequencer_if: host write port, ALU handshake and status bundle of the sequencer
//   slave  (sequencer): in en, we_IM, codein, alu_done; out reg_load*, load_data, alu_op,
//                       alu_start, ibuf_full, ibuf_empty, busy, halted, err
//   master (host/bench): the mirror image
//   CPU_SEQ_PERF_EN adds retired_cnt[15:0] (sequencer output)
interface cpu_instr_sequencer_if;
    import cpu_seq_pkg::*;
    logic              en;
    logic              we_IM;
    logic [W_WORD-1:0] codein;
    logic              alu_done;
    logic              reg_loadA;
    logic              reg_loadB;
    logic              reg_loadC;
    logic [15:0]       load_data;
    logic [3:0]        alu_op;
    logic              alu_start;
    logic              ibuf_full;
    logic              ibuf_empty;
    logic              busy;
    logic              halted;
    logic              err;
`ifdef CPU_SEQ_PERF_EN
    logic [15:0]       retired_cnt;
`endif
    modport slave (
        input  en, we_IM, codein, alu_done,
        output reg_loadA, reg_loadB, reg_loadC, load_data, alu_op, alu_start,
               ibuf_full, ibuf_empty, busy, halted, err
`ifdef CPU_SEQ_PERF_EN
        , output retired_cnt
`endif
    );
    modport master (
        output en, we_IM, codein, alu_done,
        input  reg_loadA, reg_loadB, reg_loadC, load_data, alu_op, alu_start,
               ibuf_full, ibuf_empty, busy, halted, err
`ifdef CPU_SEQ_PERF_EN
        , input retired_cnt
`endif
    );
endinterface

// File: rtl/cpu_ibuf.sv
// cpu_ibuf: synchronous instruction FIFO with show-ahead read
//   clk, rst_n (async active-low); wr/wdata push; rd pops head; rdata = head word;
//   full, empty, count (occupancy, held separately from pointers to tell full from empty)
module cpu_ibuf import cpu_seq_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W     = W_WORD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          pop, push;
    assign pop   = rd && !empty;
    // a pop in the same cycle frees the slot, so a write to a full buffer still lands
    assign push  = wr && (!full || pop);
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rp];
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: buffers host instruction words and issues them as register-load / ALU-op pulses
//   clk, rst_n (async active-low); bus: cpu_instr_sequencer_if.slave
//   params IBUF_DEPTH (power of 2, >=2), ALU_TIMEOUT (1..255 cycles in WAIT_ALU before err)
//   optional macro CPU_SEQ_PERF_EN: retired-instruction counter on bus.retired_cnt
module cpu_instr_sequencer import cpu_seq_pkg::*; #(
    parameter int IBUF_DEPTH  = 4,
    parameter int ALU_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    cpu_instr_sequencer_if.slave bus
);
    state_t                      state;
    logic [W_WORD-1:0]           rd_data, ir;
    logic [$clog2(IBUF_DEPTH):0] cnt;
    logic [7:0]                  tmr;
    logic [2:0]                  opc;
    logic                        pop, go, timeout, retire, unused_bits;
    cpu_ibuf #(.DEPTH(IBUF_DEPTH), .W(W_WORD)) u_ibuf (
        .clk(clk), .rst_n(rst_n), .wr(bus.we_IM), .wdata(bus.codein), .rd(pop), .rdata(rd_data),
        .full(bus.ibuf_full), .empty(bus.ibuf_empty), .count(cnt)
    );
    assign pop         = state == S_FETCH;
    assign opc         = ir[OPC_HI:OPC_LO];
    assign go          = bus.en && cnt != '0;
    assign timeout     = state == S_WAIT_ALU && !bus.alu_done && tmr == 8'(ALU_TIMEOUT - 1);
    assign retire      = (state == S_EXEC && opc != OP_ALU) || (state == S_WAIT_ALU && (bus.alu_done || timeout));
    assign bus.busy    = !(state inside {S_IDLE, S_HALT});
    assign bus.halted  = state == S_HALT;
    assign unused_bits = ^{ir[W_WORD-1:OPC_HI+1], ir[IMM_LO-1:0]};
    // pulses and alu_op are set on DECODE->EXEC so they are flop outputs valid for the whole EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ir            <= '0;
            tmr           <= '0;
            bus.reg_loadA <= 1'b0;
            bus.reg_loadB <= 1'b0;
            bus.reg_loadC <= 1'b0;
            bus.load_data <= '0;
            bus.alu_op    <= '0;
            bus.alu_start <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            if ((bus.we_IM && bus.ibuf_full && !pop) || timeout) bus.err <= 1'b1;
            case (state)
                S_IDLE: if (go) state <= S_FETCH;
                S_FETCH: begin
                    ir    <= rd_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    state         <= S_EXEC;
                    bus.reg_loadA <= opc == OP_LDA;
                    bus.reg_loadB <= opc == OP_LDB;
                    bus.reg_loadC <= opc == OP_LDC;
                    bus.load_data <= opc inside {OP_LDA, OP_LDB, OP_LDC} ? 16'(ir[IMM_HI:IMM_LO]) : '0;
                    bus.alu_start <= opc == OP_ALU;
                    bus.alu_op    <= opc == OP_ALU ? ir[FN_HI:FN_LO] : '0;
                end
                S_EXEC: begin
                    bus.reg_loadA <= 1'b0;
                    bus.reg_loadB <= 1'b0;
                    bus.reg_loadC <= 1'b0;
                    bus.load_data <= '0;
                    bus.alu_start <= 1'b0;
                    tmr           <= '0;
                    state         <= opc == OP_ALU ? S_WAIT_ALU : opc == OP_HALT ? S_HALT : go ? S_FETCH : S_IDLE;
                end
                S_WAIT_ALU: begin
                    tmr <= tmr + 8'd1;
                    if (retire) begin
                        bus.alu_op <= '0;
                        state      <= go ? S_FETCH : S_IDLE;
                    end
                end
                S_HALT: if (!bus.en) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef CPU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.retired_cnt <= '0;
        else if (retire) bus.retired_cnt <= bus.retired_cnt + 16'd1;
    end
`endif
endmodule
